// File: rtl/elastic_memory_responder.sv
// elastic_memory_responder: SELF-channel load/store responder over a local word-addressed SRAM model.
// Optional range checking (resp_error port, out-of-range suppression) enabled by defining ELASTIC_MEM_RANGE_CHECK_EN.
module elastic_memory_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_DEPTH     = 1024,
  parameter int ACCESS_CYCLE  = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     valid_req,
  output logic                     stop_req,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0]    req_write_data,
  output logic                     valid_resp,
  input  logic                     stop_resp,
  output logic [DATA_WIDTH-1:0]    resp_data,
  input  logic                     init_we,
  input  logic [ADDRESS_WIDTH-1:0] init_address,
  input  logic [DATA_WIDTH-1:0]    init_data
`ifdef ELASTIC_MEM_RANGE_CHECK_EN
  ,
  output logic                     resp_error
`endif
);
  localparam int IW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam int CW = $clog2(ACCESS_CYCLE + 1);
  if (ACCESS_CYCLE < 1) begin : g_bad_cycle
    $error("ACCESS_CYCLE must be at least 1");
  end
  typedef enum logic [1:0] {IDLE = 2'b00, ACCESS = 2'b01, RESPOND = 2'b10} state_t;
  state_t                   state_q;
  logic [CW-1:0]            cnt_q;
  logic                     wr_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [DATA_WIDTH-1:0]    resp_data_q;
  logic                     err_q;
  logic [DATA_WIDTH-1:0]    mem_q [MEM_DEPTH];
  logic                     accept;
  logic                     fire_now;
  logic                     acc_fire;
  logic                     acc_write;
  logic [ADDRESS_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0]    acc_data;
  logic [IW-1:0]            acc_idx;
  logic [IW-1:0]            init_idx;
  logic                     init_ok;
  logic                     acc_ok;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     unused_bits;
  assign stop_req   = state_q != IDLE;
  assign valid_resp = state_q == RESPOND;
  assign resp_data  = resp_data_q;
  assign accept     = reset_n && valid_req && !stop_req;
  // With a single-cycle access the request is served straight off the inputs on the accepting edge.
  assign fire_now   = accept && ACCESS_CYCLE == 1;
  assign acc_fire   = fire_now || (state_q == ACCESS && cnt_q == CW'(1));
  assign acc_write  = fire_now ? req_write : wr_q;
  assign acc_addr   = fire_now ? req_address : addr_q;
  assign acc_data   = fire_now ? req_write_data : data_q;
  assign acc_idx    = acc_addr[IW-1:0];
  assign init_idx   = init_address[IW-1:0];
`ifdef ELASTIC_MEM_RANGE_CHECK_EN
  assign acc_ok     = acc_addr < ADDRESS_WIDTH'(MEM_DEPTH);
  assign init_ok    = reset_n && init_we && state_q == IDLE && init_address < ADDRESS_WIDTH'(MEM_DEPTH);
  assign resp_error = err_q;
`else
  assign acc_ok     = 1'b1;
  assign init_ok    = reset_n && init_we && state_q == IDLE;
`endif
  // A preload in the same cycle as the access lands first, so the read forwards it.
  assign rd_data     = !acc_ok ? '0 : (init_ok && init_idx == acc_idx) ? init_data : mem_q[acc_idx];
  assign unused_bits = ^{req_address, init_address, addr_q, err_q};
  // Array write ports: preload first, then the request store so a same-address store wins.
  always_ff @(posedge clk) begin
    if (init_ok) mem_q[init_idx] <= init_data;
    if (acc_fire && acc_write && acc_ok) mem_q[acc_idx] <= acc_data;
  end
  // Request FSM: accept, count down the access latency, hold the response until it is taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      resp_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_address;
        data_q  <= req_write_data;
        cnt_q   <= CW'(ACCESS_CYCLE - 1);
        state_q <= ACCESS_CYCLE == 1 ? RESPOND : ACCESS;
      end
      if (state_q == ACCESS) begin
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_q <= RESPOND;
      end
      if (acc_fire) begin
        resp_data_q <= acc_write ? acc_data : rd_data;
        err_q       <= !acc_ok;
      end
      if (state_q == RESPOND && !stop_resp) state_q <= IDLE;
    end
  end
endmodule
